// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter sharing a single signed adder/subtractor.
// Each accepted request passes through IDLE -> EXEC -> DONE, so the unit
// completes at most one operation every three cycles. All outputs are registered.
module addsub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    req0,
  input  logic                    op0,
  input  logic signed [WIDTH-1:0] a0,
  input  logic signed [WIDTH-1:0] b0,
  input  logic                    req1,
  input  logic                    op1,
  input  logic signed [WIDTH-1:0] a1,
  input  logic signed [WIDTH-1:0] b1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    busy,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf,
  output logic                    done,
  output logic                    done_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       prio;
  logic       any_req;
  logic       win;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    op_p0;
  logic                    id_p0;

  logic signed [WIDTH-1:0] b_eff;
  logic signed [WIDTH-1:0] sum;
  logic                    sum_ovf;

  // Subtraction reuses the adder: A - B = A + ~B + 1, wrapping modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] addsub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b_in,
    input logic                    sub
  );
    logic [WIDTH-1:0] carry;
    carry = {{(WIDTH-1){1'b0}}, sub};
    return a + b_in + carry;
  endfunction

  // Overflow: both adder inputs share a sign but the sum's sign differs.
  function automatic logic ovf_flag(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Winner selection: a lone requester always wins, otherwise prio decides.
  always_comb begin
    any_req = req0 | req1;
    win     = req1 & (~req0 | prio);
  end

  // Shared adder operating on the captured operands during EXEC.
  always_comb begin
    b_eff   = op_p0 ? ~b_p0 : b_p0;
    sum     = addsub(a_p0, b_eff, op_p0);
    sum_ovf = ovf_flag(a_p0[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
  end

  // ---- stage p0: operand capture at the IDLE edge that accepts a request ----
  // Operand registers carry data only, so they are left out of reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      a_p0  <= win ? a1 : a0;
      b_p0  <= win ? b1 : b0;
      op_p0 <= win ? op1 : op0;
    end
  end

  // ---- stage p1: FSM, grant/done pulses and result registers ----
  // Reset aborts any operation in flight and clears the visible result.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      prio    <= 1'b0;
      id_p0   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (any_req) begin
            state <= EXEC;
            id_p0 <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            busy  <= 1'b1;
            prio  <= ~win;
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
          end
        end
        EXEC: begin
          state   <= DONE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          done    <= 1'b1;
          result  <= sum;
          ovf     <= sum_ovf;
          done_id <= id_p0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed vector table, randomized operations
// checked against a wide-integer arithmetic model, and hand-written sequences
// for round-robin, reset abort and late-request behaviour.
module tb_addsub_arbiter;

  logic        clk;
  logic        clr_n;
  logic        req0, op0, req1, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, ovf, done, done_id;
  logic [31:0] result;

  int pass_cnt;
  int total_cnt;

  addsub_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .clr_n(clr_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .result(result), .ovf(ovf), .done(done), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    bit          exp_o;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: exact integer arithmetic, then truncate and range-check.
  function automatic void model(input bit op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit v);
    longint sa, sb, f;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    f  = op ? (sa - sb) : (sa + sb);
    r  = f[31:0];
    v  = (f > 64'sd2147483647) || (f < -64'sd2147483648);
  endfunction

  task automatic do_reset();
    clr_n = 1'b0;
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic run_op(input bit id, input bit op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit eo, input string tag);
    int n;
    @(negedge clk);
    if (id) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? gnt1 : gnt0) && n < 8);
    chk({tag, "_gnt"},       64'(id ? gnt1 : gnt0), 64'd1);
    chk({tag, "_gnt_other"}, 64'(id ? gnt0 : gnt1), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd1);
    // Drop request and disturb operands; the captured values must be used.
    req0 = 0; req1 = 0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 1'($urandom); op1 = 1'($urandom);
    @(negedge clk);
    chk({tag, "_done"},    64'(done), 64'd1);
    chk({tag, "_result"},  64'(result), 64'(er));
    chk({tag, "_ovf"},     64'(ovf), 64'(eo));
    chk({tag, "_done_id"}, 64'(done_id), 64'(id));
    chk({tag, "_nognt"},   64'(gnt0 | gnt1), 64'd0);
    @(negedge clk);
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_idle"},     64'(busy), 64'd0);
    chk({tag, "_hold"},     64'(result), 64'(er));
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] r;
    bit v;
    pass_cnt = 0; total_cnt = 0;
    clr_n = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;

    vecs.push_back('{0, 0, 32'd5,          32'd7,          32'd12,         0});
    vecs.push_back('{1, 1, 32'd3,          32'd10,         32'hFFFFFFF9,   0});
    vecs.push_back('{0, 0, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1});
    vecs.push_back('{1, 1, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1});
    vecs.push_back('{0, 1, 32'd0,          32'h80000000,   32'h80000000,   1});
    vecs.push_back('{1, 0, 32'h80000000,   32'h80000000,   32'h00000000,   1});
    vecs.push_back('{0, 0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   0});
    vecs.push_back('{1, 1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   0});
    vecs.push_back('{1, 1, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000,   1});

    // Reset values
    #1 clr_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    clr_n = 1;

    // Directed vector table
    foreach (vecs[i])
      run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_o,
             $sformatf("vec%0d", i));

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      bit rid, rop;
      logic [31:0] ra, rb;
      rid = 1'($urandom); rop = 1'($urandom);
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) ra = {ra[31], 31'h7FFFFFF0} ^ {1'b0, 27'd0, ra[3:0]};
      model(rop, ra, rb, r, v);
      run_op(rid, rop, ra, rb, r, v, $sformatf("rnd%0d", i));
    end

    // Both requesters held high: grants alternate 0,1,0,1 three cycles apart
    begin
      int gcyc[$], gid[$], dcyc[$], did[$];
      int exp_g[4] = '{1, 4, 7, 10};
      int overlap;
      do_reset();
      @(negedge clk);
      req0 = 1; op0 = 0; a0 = 32'd100; b0 = 32'd1;
      req1 = 1; op1 = 1; a1 = 32'd50;  b1 = 32'd8;
      overlap = 0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if ((gnt0 && gnt1) || (done && (gnt0 || gnt1))) overlap++;
        if (gnt0 || gnt1) begin gcyc.push_back(c); gid.push_back(gnt1 ? 1 : 0); end
        if (done) begin
          dcyc.push_back(c); did.push_back(int'(done_id));
          chk($sformatf("rr_result%0d", dcyc.size()), 64'(result),
              (dcyc.size() % 2 == 1) ? 64'd101 : 64'd42);
        end
      end
      req0 = 0; req1 = 0;
      chk("rr_overlap", 64'(overlap), 64'd0);
      chk("rr_ngnt", 64'(gcyc.size()), 64'd4);
      chk("rr_ndone", 64'(dcyc.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < gcyc.size()) begin
          chk($sformatf("rr_gcyc%0d", k), 64'(gcyc[k]), 64'(exp_g[k]));
          chk($sformatf("rr_gid%0d", k), 64'(gid[k]), 64'(k % 2));
        end
        if (k < dcyc.size()) begin
          chk($sformatf("rr_dcyc%0d", k), 64'(dcyc[k]), 64'(exp_g[k] + 1));
          chk($sformatf("rr_did%0d", k), 64'(did[k]), 64'(k % 2));
        end
      end
    end

    // Reset during EXEC aborts the operation
    begin
      int saw_done;
      @(negedge clk);
      @(negedge clk);
      req0 = 1; op0 = 0; a0 = 32'd5; b0 = 32'd7;
      @(negedge clk);
      chk("abort_gnt0", 64'(gnt0), 64'd1);
      #2 clr_n = 0; req0 = 0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_gnt", 64'(gnt0 | gnt1), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      @(negedge clk);
      clr_n = 1;
      saw_done = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) saw_done++;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
      chk("abort_result_after", 64'(result), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end

    // Request from requester 1 raised during EXEC of requester 0
    begin
      @(negedge clk);
      req0 = 1; op0 = 0; a0 = 32'd20; b0 = 32'd22;
      @(negedge clk);
      chk("late_gnt0", 64'(gnt0), 64'd1);
      req0 = 0; req1 = 1; op1 = 0; a1 = 32'd1; b1 = 32'd2;
      @(negedge clk);
      chk("late_done0", 64'(done), 64'd1);
      chk("late_result0", 64'(result), 64'd42);
      chk("late_gnt1_done", 64'(gnt1), 64'd0);
      @(negedge clk);
      chk("late_gnt1_idle", 64'(gnt1), 64'd0);
      chk("late_busy_idle", 64'(busy), 64'd0);
      @(negedge clk);
      chk("late_gnt1", 64'(gnt1), 64'd1);
      req1 = 0;
      @(negedge clk);
      chk("late_done1", 64'(done), 64'd1);
      chk("late_result1", 64'(result), 64'd3);
      chk("late_done_id1", 64'(done_id), 64'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
